regfile_writeback: RTL
======================

# regfile_writeback

Write-back and architected-register-state unit sitting directly after the ALU in the execute path. It accepts one result record per handshake and commits it into the 16 x 64-bit general-purpose register file. A record carries up to two destination writes (two for imul: rax and rdx). The unit exports the flat register image and two operand read ports that feed the ALU's next instruction.

## Interface
- NREGS, 16, number of architected 64-bit registers (index width is log2(NREGS) = 4)
- DATA_W, 64, register width
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  result record present
- in_ready  out  1  unit can accept a record this cycle
- in_dst0_en  in  1  first write enabled (0 for compare/no-write records)
- in_dst0  in  4  first destination register number
- in_val0  in  64  first write value
- in_dst1_en  in  1  second write enabled (imul high half)
- in_dst1  in  4  second destination register number
- in_val1  in  64  second write value
- in_halt  in  1  record is retq/null opcode; stop retiring
- rd_a_idx, rd_b_idx  in  4 each  operand read indices
- rd_a_data, rd_b_data  out  64 each  operand read data (combinational)
- reg_file_out  out  NREGS*64  flat image, bits [0:63] = reg 0, reg n at [64n : 64n+63]
- busy  out  1  second write pending
- halted  out  1  halt record retired
- retired_count  out  32  records retired since reset

## Operation
- States: IDLE, WRITE1, HALTED. Reset state IDLE.
- in_ready = 1 only in IDLE; a record is accepted when in_valid & in_ready at a rising edge.
- IDLE, accept, in_halt=1: no register writes regardless of enables; -> HALTED; retired_count += 1.
- IDLE, accept, in_halt=0, in_dst1_en=0: write in_val0 to in_dst0 if in_dst0_en; retired_count += 1; stay IDLE.
- IDLE, accept, in_halt=0, in_dst1_en=1: write dst0 if enabled; latch dst1/val1 into pending registers; -> WRITE1; no count yet.
- WRITE1: write pending val1 to pending dst1; retired_count += 1; -> IDLE. in_valid is ignored.
- HALTED: sticky until reset; in_ready=0; no writes; inputs ignored.
- Single write port per cycle; dst0 and dst1 are never written in the same cycle.
- dst0 == dst1: final value is val1, because it is written second.
- Read ports: return the register file contents. In WRITE1, a read of the pending dst1 index returns the pending val1 (bypass). No bypass of an in-flight dst0: it becomes visible the cycle after acceptance.
- reg_file_out reflects committed registers only (no bypass).
- busy = (state == WRITE1); halted = (state == HALTED).
- retired_count wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (asserted at any time, including mid-WRITE1): all registers = 0, pending latch cleared, state IDLE, in_ready=1, busy=0, halted=0, retired_count=0, rd_*_data=0. Any pending dst1 write is discarded.
- Single-write record: value is visible on reg_file_out and the read ports 1 cycle after the accepting edge. Throughput is 1 record/cycle.
- Dual-write record: dst0 is visible at +1 cycle; dst1 is visible at +1 via bypass and committed at +2; throughput is 1 record per 2 cycles. in_ready is low for exactly 1 cycle.
- Halt: halted rises 1 cycle after the accepting edge; in_ready falls at the same time.

## Test plan
- Reset, then read all 16 indices -> each returns 0; in_ready=1, halted=0, retired_count=0.
- Back-to-back records dst0=3 val 0x1111 then dst0=3 val 0x2222, both in_dst1_en=0 -> reg 3 = 0x2222 after cycle 2; retired_count=2; in_ready stays 1.
- imul record: dst0=0 val 0xDEAD, dst1=2 val 0xBEEF -> at +1: busy=1, in_ready=0, rd_a_idx=2 returns 0xBEEF while reg_file_out reg 2 is still 0. At +2: reg 2 = 0xBEEF, busy=0, retired_count=1.
- Same-destination dual write: dst0=dst1=5, val0=0xA, val1=0xB -> reg 5 = 0xB at +2.
- Halt record with in_dst0_en=1 dst0=1 val0=7 -> reg 1 stays 0, halted=1, in_ready=0. A following in_valid record has no effect. Reset then clears halted.
- Reset asserted in WRITE1 (dst1=4 pending) -> reg 4 = 0 asynchronously, state IDLE, busy=0, retired_count=0.

Source files
------------

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Write-back stage committing ALU result records (up to two
//               destination writes each) into the architected register file.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
    parameter int NREGS  = 16,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_dst0_en,
    input  logic [IDX_W-1:0]        in_dst0,
    input  logic [DATA_W-1:0]       in_val0,
    input  logic                    in_dst1_en,
    input  logic [IDX_W-1:0]        in_dst1,
    input  logic [DATA_W-1:0]       in_val1,
    input  logic                    in_halt,
    input  logic [IDX_W-1:0]        rd_a_idx,
    input  logic [IDX_W-1:0]        rd_b_idx,
    output logic [DATA_W-1:0]       rd_a_data,
    output logic [DATA_W-1:0]       rd_b_data,
    output logic [NREGS*DATA_W-1:0] reg_file_out,
    output logic                    busy,
    output logic                    halted,
    output logic [31:0]             retired_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WRITE1 = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [IDX_W-1:0]  r_pend_dst;
    logic [DATA_W-1:0] r_pend_val;
    logic [31:0]       r_retired;

    logic              w_accept;
    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_latch;
    logic              w_retire;
    logic              w_bypass_a;
    logic              w_bypass_b;

    assign w_accept = in_valid && (r_state == c_IDLE);

    // Single write port: dst0 on the accepting edge, pending dst1 one edge later.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = in_dst0;
        w_wdata     = in_val0;
        w_latch     = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (in_halt) begin
                        w_state_nxt = c_HALTED;
                        w_retire    = 1'b1;
                    end else begin
                        w_we = in_dst0_en;
                        if (in_dst1_en) begin
                            w_latch     = 1'b1;
                            w_state_nxt = c_WRITE1;
                        end else begin
                            w_retire = 1'b1;
                        end
                    end
                end
            end
            c_WRITE1: begin
                w_we        = 1'b1;
                w_waddr     = r_pend_dst;
                w_wdata     = r_pend_val;
                w_retire    = 1'b1;
                w_state_nxt = c_IDLE;
            end
            c_HALTED: begin
                w_state_nxt = c_HALTED;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_dst <= '0;
            r_pend_val <= '0;
        end else if (w_latch) begin
            r_pend_dst <= in_dst1;
            r_pend_val <= in_val1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    // The pending high-half write is forwarded so the next ALU op sees it early.
    assign w_bypass_a = (r_state == c_WRITE1) && (rd_a_idx == r_pend_dst);
    assign w_bypass_b = (r_state == c_WRITE1) && (rd_b_idx == r_pend_dst);
    assign rd_a_data  = w_bypass_a ? r_pend_val : r_regs[rd_a_idx];
    assign rd_b_data  = w_bypass_b ? r_pend_val : r_regs[rd_b_idx];

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_flat
            assign reg_file_out[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign in_ready      = (r_state == c_IDLE);
    assign busy          = (r_state == c_WRITE1);
    assign halted        = (r_state == c_HALTED);
    assign retired_count = r_retired;

endmodule
`default_nettype wire
